// File: rtl/instruction_loader_pkg.sv
// ---------------------------------------------------------------------------
// instruction_loader_pkg
// Shared types for the instruction loader: the machine word / half-word types
// used on the instruction RAM write port, and the loader state enumeration.
// ---------------------------------------------------------------------------
package instruction_loader_pkg;

   localparam int WORD_W      = 32;
   localparam int HALF_WORD_W = 16;

   typedef logic [WORD_W-1:0]      word_t;
   typedef logic [HALF_WORD_W-1:0] half_word_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LEN_LO  = 3'd1,
      LEN_HI  = 3'd2,
      DATA_LO = 3'd3,
      DATA_HI = 3'd4,
      WRITE   = 3'd5,
      DONE    = 3'd6,
      ERROR   = 3'd7
   } loader_state_t;

endpackage : instruction_loader_pkg

// File: rtl/instruction_loader.sv
// ---------------------------------------------------------------------------
// instruction_loader
// Receives a program image as a byte stream and writes it into instruction RAM
// while holding the CPU. Stream format: 16-bit little-endian half-word count N,
// then N half-words, each sent low byte first.
//
// Ports
//   clk_i          : clock, all state on the rising edge
//   reset_i        : asynchronous active-high reset, returns to IDLE
//   start_i        : pulse, starts a load session from IDLE, DONE or ERROR
//   byte_valid_i   : upstream byte available
//   byte_i         : upstream byte
//   byte_ready_o   : byte taken on an edge where byte_valid_i is also high
//   ram_write_en_o : one-cycle write strobe to the instruction RAM
//   ram_addr_o     : byte address of the half-word being written
//   ram_data_o     : half-word being written
//   cpu_hold_o     : keeps the CPU in reset / off the fetch port while high
//   load_done_o    : load completed successfully
//   load_error_o   : header count was larger than RAM_HALF_WORDS
// ---------------------------------------------------------------------------
module instruction_loader
   import instruction_loader_pkg::*;
#(
   parameter int    RAM_HALF_WORDS = 1024,
   parameter word_t BASE_ADDR      = '0
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       start_i,
   input  logic       byte_valid_i,
   input  logic [7:0] byte_i,
   output logic       byte_ready_o,
   output logic       ram_write_en_o,
   output word_t      ram_addr_o,
   output half_word_t ram_data_o,
   output logic       cpu_hold_o,
   output logic       load_done_o,
   output logic       load_error_o
);

   localparam word_t RAM_HW = word_t'(RAM_HALF_WORDS);

   loader_state_t r_state, w_state_next;
   word_t         r_addr;
   half_word_t    r_data;
   logic [15:0]   r_count;
   logic [7:0]    r_len_lo;

   logic          w_take;
   logic [15:0]   w_len;

   // Full count is only known in LEN_HI, where the high byte is on byte_i.
   assign w_len  = {byte_i, r_len_lo};
   assign w_take = byte_ready_o & byte_valid_i;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      byte_ready_o   = 1'b0;
      ram_write_en_o = 1'b0;
      cpu_hold_o     = 1'b1;
      load_done_o    = 1'b0;
      load_error_o   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start_i) w_state_next = LEN_LO;
         end
         LEN_LO: begin
            byte_ready_o = 1'b1;
            if (byte_valid_i) w_state_next = LEN_HI;
         end
         LEN_HI: begin
            byte_ready_o = 1'b1;
            if (byte_valid_i) begin
               if (w_len == 16'd0)                    w_state_next = DONE;
               else if ({16'd0, w_len} > RAM_HW)      w_state_next = ERROR;
               else                                   w_state_next = DATA_LO;
            end
         end
         DATA_LO: begin
            byte_ready_o = 1'b1;
            if (byte_valid_i) w_state_next = DATA_HI;
         end
         DATA_HI: begin
            byte_ready_o = 1'b1;
            if (byte_valid_i) w_state_next = WRITE;
         end
         WRITE: begin
            ram_write_en_o = 1'b1;
            w_state_next   = (r_count == 16'd1) ? DONE : DATA_LO;
         end
         DONE: begin
            cpu_hold_o  = 1'b0;
            load_done_o = 1'b1;
            if (start_i) w_state_next = LEN_LO;
         end
         ERROR: begin
            load_error_o = 1'b1;
            if (start_i) w_state_next = LEN_LO;
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_addr   <= BASE_ADDR;
         r_data   <= '0;
         r_count  <= '0;
         r_len_lo <= '0;
      end else begin
         case (r_state)
            LEN_LO: if (w_take) r_len_lo <= byte_i;
            LEN_HI: begin
               if (w_take) begin
                  r_count <= w_len;
                  r_addr  <= BASE_ADDR;
               end
            end
            DATA_LO: if (w_take) r_data[7:0]  <= byte_i;
            DATA_HI: if (w_take) r_data[15:8] <= byte_i;
            WRITE: begin
               r_count <= r_count - 16'd1;
               // The address is not advanced past the final half-word, so it
               // never points beyond the last RAM location.
               if (r_count != 16'd1) r_addr <= r_addr + word_t'(2);
            end
            default: ;
         endcase
      end
   end

   assign ram_addr_o = r_addr;
   assign ram_data_o = r_data;

endmodule : instruction_loader

// File: tb/tb_instruction_loader.sv
// ---------------------------------------------------------------------------
// tb_instruction_loader
// Drives load sessions (directed and random) into instruction_loader and
// compares the RAM writes and final status against a reference computed
// directly from the byte stream.
// ---------------------------------------------------------------------------
module tb_instruction_loader;
   import instruction_loader_pkg::*;

   localparam int    RAM_HW = 1024;
   localparam word_t BASE   = '0;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       start_i;
   logic       byte_valid_i;
   logic [7:0] byte_i;
   logic       byte_ready_o;
   logic       ram_write_en_o;
   word_t      ram_addr_o;
   half_word_t ram_data_o;
   logic       cpu_hold_o;
   logic       load_done_o;
   logic       load_error_o;

   int n_total = 0;
   int n_bad   = 0;

   logic [7:0]  stim_q[$];
   logic [47:0] wr_q[$];

   instruction_loader #(.RAM_HALF_WORDS(RAM_HW), .BASE_ADDR(BASE)) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .start_i        (start_i),
      .byte_valid_i   (byte_valid_i),
      .byte_i         (byte_i),
      .byte_ready_o   (byte_ready_o),
      .ram_write_en_o (ram_write_en_o),
      .ram_addr_o     (ram_addr_o),
      .ram_data_o     (ram_data_o),
      .cpu_hold_o     (cpu_hold_o),
      .load_done_o    (load_done_o),
      .load_error_o   (load_error_o)
   );

   always #5 clk_i = ~clk_i;

   // Capture every cycle the write strobe is high; a stretched pulse shows
   // up as an extra write.
   always @(negedge clk_i) begin
      if (ram_write_en_o) wr_q.push_back({ram_addr_o, ram_data_o});
   end

   task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "/we"},    48'(ram_write_en_o), 48'd0);
      chk({tag, "/addr"},  48'(ram_addr_o),     48'(BASE));
      chk({tag, "/data"},  48'(ram_data_o),     48'd0);
      chk({tag, "/ready"}, 48'(byte_ready_o),   48'd0);
      chk({tag, "/hold"},  48'(cpu_hold_o),     48'd1);
      chk({tag, "/done"},  48'(load_done_o),    48'd0);
      chk({tag, "/err"},   48'(load_error_o),   48'd0);
   endtask

   // Called at posedge+1; returns at posedge+1 after the byte is taken.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      byte_valid_i = 1'b1;
      byte_i       = b;
      while (1) begin
         @(negedge clk_i);
         if (byte_ready_o) break;
         n++;
         if (n > 50) begin
            chk("send_timeout", 48'd0, 48'd1);
            break;
         end
      end
      @(posedge clk_i); #1;
      byte_valid_i = 1'b0;
      byte_i       = 8'($urandom);
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
   endtask

   // Runs stim_q as one session. start_at / stall_idx = -1 disable those.
   task automatic run_session(input string tag, input int gap_max,
                              input int stall_idx, input int start_at);
      int          n, k, sz;
      logic        exp_done, exp_err;
      logic [47:0] exp_w;
      wr_q.delete();
      pulse_start();
      @(negedge clk_i);
      chk({tag, "/start_hold"},  48'(cpu_hold_o),   48'd1);
      chk({tag, "/start_done"},  48'(load_done_o),  48'd0);
      chk({tag, "/start_ready"}, 48'(byte_ready_o), 48'd1);
      @(posedge clk_i); #1;
      for (int i = 0; i < stim_q.size(); i++) begin
         if (i == start_at) pulse_start();
         if (i == stall_idx) begin
            sz = wr_q.size();
            repeat (10) begin @(posedge clk_i); #1; end
            @(negedge clk_i);
            chk({tag, "/stall_ready"}, 48'(byte_ready_o), 48'd1);
            chk({tag, "/stall_wr"},    48'(wr_q.size()),  48'(sz));
            @(posedge clk_i); #1;
         end else if (gap_max > 0) begin
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk_i); #1; end
         end
         send_byte(stim_q[i]);
      end
      k = 0;
      do begin
         @(negedge clk_i);
         k++;
      end while (!(load_done_o || load_error_o) && k < 40);
      if (!(load_done_o || load_error_o)) chk({tag, "/end_timeout"}, 48'd0, 48'd1);

      // Reference: header count, then half-words low byte first.
      n        = {stim_q[1], stim_q[0]};
      exp_done = (n <= RAM_HW);
      exp_err  = (n > RAM_HW);
      if (exp_err) n = 0;
      chk({tag, "/nwr"}, 48'(wr_q.size()), 48'(n));
      for (int i = 0; i < n && i < wr_q.size(); i++) begin
         exp_w = {BASE + 32'(2 * i), stim_q[3 + 2 * i], stim_q[2 + 2 * i]};
         chk($sformatf("%s/wr%0d", tag, i), wr_q[i], exp_w);
      end
      chk({tag, "/done"},  48'(load_done_o),  48'(exp_done));
      chk({tag, "/err"},   48'(load_error_o), 48'(exp_err));
      chk({tag, "/hold"},  48'(cpu_hold_o),   48'(!exp_done));
      chk({tag, "/ready"}, 48'(byte_ready_o), 48'd0);
      $display("session %s: N=%0d writes=%0d done=%0b err=%0b",
               tag, {stim_q[1], stim_q[0]}, wr_q.size(), load_done_o, load_error_o);
      @(posedge clk_i); #1;
   endtask

   task automatic load_stim(input int n, input logic [15:0] hdr);
      stim_q.delete();
      stim_q.push_back(hdr[7:0]);
      stim_q.push_back(hdr[15:8]);
      for (int i = 0; i < 2 * n; i++) stim_q.push_back(8'($urandom));
   endtask

   initial begin
      int n;
      int r;
      reset_i      = 1'b1;
      start_i      = 1'b0;
      byte_valid_i = 1'b0;
      byte_i       = 8'h00;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk_reset_outputs("reset");
      @(posedge clk_i); #1;
      reset_i = 1'b0;
      @(negedge clk_i);
      chk_reset_outputs("idle");
      @(posedge clk_i); #1;

      // Two half-words, documented example stream.
      stim_q = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
      run_session("basic", 0, -1, -1);

      stim_q = '{8'h00, 8'h00};
      run_session("zero_len", 0, -1, -1);

      stim_q = '{8'h01, 8'h04};
      run_session("too_long", 0, -1, -1);

      stim_q = '{8'hFF, 8'hFF};
      run_session("len_ffff", 0, -1, -1);

      // Ten idle cycles between the low and high data bytes.
      stim_q = '{8'h01, 8'h00, 8'h34, 8'h12};
      run_session("stall", 0, 3, -1);

      // start_i while waiting for the first data byte must be ignored.
      stim_q = '{8'h02, 8'h00, 8'hCD, 8'hAB, 8'h01, 8'hEF};
      run_session("start_ignored", 1, -1, 2);

      // Reset part-way through a four-half-word load.
      wr_q.delete();
      pulse_start();
      send_byte(8'h04);
      send_byte(8'h00);
      #3 reset_i = 1'b1;
      #1 chk_reset_outputs("midreset_async");
      @(posedge clk_i); #1;
      reset_i = 1'b0;
      @(negedge clk_i);
      chk_reset_outputs("midreset");
      chk("midreset/nwr", 48'(wr_q.size()), 48'd0);
      @(posedge clk_i); #1;
      load_stim(4, 16'd4);
      run_session("reload", 2, -1, -1);

      // Exactly full RAM: last write lands on the top location.
      load_stim(RAM_HW, 16'(RAM_HW));
      run_session("full_ram", 0, -1, -1);

      for (int s = 0; s < 25; s++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      n = 0;
         else if (r == 1) n = $urandom_range(RAM_HW + 1, 65535);
         else             n = $urandom_range(1, 8);
         load_stim((n > RAM_HW) ? 0 : n, 16'(n));
         run_session($sformatf("rand%0d", s), 3, -1, -1);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule : tb_instruction_loader
